// File: rtl/alarm_timekeeper_if.sv
// Control/load inputs and time/alarm outputs of the alarm timekeeper.
interface alarm_timekeeper_if;
  logic       tick;
  logic       set_time;
  logic       set_alarm;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [2:0] set_day;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [2:0] day;
  logic       ring;
  logic       day_wrap;

  modport master (
    output tick, set_time, set_alarm, set_hour, set_min, set_day,
           alarm_en, snooze, stop,
    input  sec, min, hour, day, ring, day_wrap
  );

  modport slave (
    input  tick, set_time, set_alarm, set_hour, set_min, set_day,
           alarm_en, snooze, stop,
    output sec, min, hour, day, ring, day_wrap
  );
endinterface

// File: rtl/alarm_timekeeper.sv
// Weekly time-of-day counter with a weekday alarm, snooze and ring timeout.
module alarm_timekeeper #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  alarm_timekeeper_if.slave bus
);
  localparam int unsigned SNZ_W  = 12;
  localparam int unsigned RING_W = 8;
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60);
  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t state, state_nx;
  logic [5:0] sec_q, min_q, al_min_q;
  logic [4:0] hour_q, al_hour_q;
  logic [2:0] day_q;
  logic       ring_q, wrap_q, ring_nx;
  logic [RING_W-1:0] ring_left, ring_left_nx;
  logic [SNZ_W-1:0]  snz_left, snz_left_nx;

  logic       sec_wrap, min_wrap, hour_wrap, day_carry, advance, trigger;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;
  logic [2:0] day_inc;

  // Incremented time, used both for the tick update and the alarm match
  always_comb begin
    sec_wrap  = (sec_q == 6'd59);
    min_wrap  = (min_q == 6'd59);
    hour_wrap = (hour_q == 5'd23);
    day_carry = sec_wrap & min_wrap & hour_wrap;
    sec_inc   = sec_wrap ? 6'd0 : sec_q + 6'd1;
    min_inc   = sec_wrap ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
    hour_inc  = (sec_wrap & min_wrap) ? (hour_wrap ? 5'd0 : hour_q + 5'd1) : hour_q;
    day_inc   = day_carry ? ((day_q == 3'd6) ? 3'd0 : day_q + 3'd1) : day_q;
    advance   = bus.tick & ~bus.set_time;
    trigger   = advance & bus.alarm_en & sec_wrap &
                (hour_inc == al_hour_q) & (min_inc == al_min_q) &
                (day_inc >= 3'd1) & (day_inc <= 3'd5);
  end

  // Time and alarm registers; out-of-range load fields leave their register alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q     <= '0;
      min_q     <= '0;
      hour_q    <= '0;
      day_q     <= '0;
      wrap_q    <= 1'b0;
      al_hour_q <= '0;
      al_min_q  <= '0;
    end else begin
      wrap_q <= advance & day_carry;
      if (bus.set_time) begin
        sec_q <= '0;
        if (bus.set_hour <= 5'd23) hour_q <= bus.set_hour;
        if (bus.set_min  <= 6'd59) min_q  <= bus.set_min;
        if (bus.set_day  != 3'd7)  day_q  <= bus.set_day;
      end else if (bus.tick) begin
        sec_q  <= sec_inc;
        min_q  <= min_inc;
        hour_q <= hour_inc;
        day_q  <= day_inc;
      end
      if (bus.set_alarm) begin
        if (bus.set_hour <= 5'd23) al_hour_q <= bus.set_hour;
        if (bus.set_min  <= 6'd59) al_min_q  <= bus.set_min;
      end
    end
  end

  // FSM state register with its countdowns and the registered ring output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ring_q    <= 1'b0;
      ring_left <= '0;
      snz_left  <= '0;
    end else begin
      state     <= state_nx;
      ring_q    <= ring_nx;
      ring_left <= ring_left_nx;
      snz_left  <= snz_left_nx;
    end
  end

  // Next state; stop beats snooze, disarming beats everything
  always_comb begin
    state_nx = state;
    if (!bus.alarm_en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (trigger) state_nx = RINGING;
        RINGING: begin
          if (bus.stop)                                  state_nx = IDLE;
          else if (bus.snooze)                           state_nx = SNOOZED;
          else if (bus.tick && ring_left == RING_W'(1))  state_nx = IDLE;
        end
        SNOOZED: begin
          if (bus.stop)                                  state_nx = IDLE;
          else if (bus.tick && snz_left == SNZ_W'(1))    state_nx = RINGING;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Countdown loads on entry, decrements on ticks while in the owning state
  always_comb begin
    ring_left_nx = ring_left;
    snz_left_nx  = snz_left;
    ring_nx      = (state_nx == RINGING);
    if (state != RINGING && state_nx == RINGING)
      ring_left_nx = RING_LOAD;
    else if (state == RINGING && bus.tick)
      ring_left_nx = ring_left - RING_W'(1);
    if (state == RINGING && state_nx == SNOOZED)
      snz_left_nx = SNZ_LOAD;
    else if (state == SNOOZED && bus.tick)
      snz_left_nx = snz_left - SNZ_W'(1);
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hour     = hour_q;
  assign bus.day      = day_q;
  assign bus.ring     = ring_q;
  assign bus.day_wrap = wrap_q;
endmodule
